// File: rtl/ddr5_phy_wrdata_burst_gen.sv
// ddr5_phy_wrdata_burst_gen
//
// Write-data burst generator for the DDR5 PHY write path. Enabled DFI write
// phases are compacted into a beat-pair FIFO. Bursts (BC8/BL16/BL32) are sent
// out at one beat-pair per clock, framed by a programmable DQS preamble and
// postamble. Back-to-back bursts are joined seamlessly when more data is
// already queued.
//
// Optional feature macro: DDR5_WR_CRC_EN. When it is defined and cfg_crc_i is
// latched as 1, a CRC8 slot follows every 8 data clocks of a burst.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            0 blocks FIFO writes; queued and in-flight data still drains
//   cfg_bl_i            00 BL16, 01 BC8, 10 BL32, 11 treated as BL16
//   cfg_pre_i           preamble length minus one (1..4 clocks)
//   cfg_post_i          0: 0.5-clock postamble, 1: 1.5-clock postamble
//   cfg_crc_i           insert CRC slots (only with DDR5_WR_CRC_EN)
//   dfi_wrdata_en_i     per-phase valid, bit0 = phase 0
//   dfi_wrdata_i        per-phase beat-pair, phase 0 in the LSBs
//   dfi_wrdata_mask_i   per-phase mask, 1 = masked
//   DQ_o                beat-pair; low half is the first beat
//   DQ_valid_o          DQ_o/DM_o carry burst or CRC data
//   DM_o                data mask for the current beat-pair
//   DQS_o               [1] first half-clock level, [0] second half-clock level
//   DQS_valid_o         per-half-clock DQS drive enable
//   busy_o              FSM active or FIFO holds data
//   ovf_err_o           pulse: at least one beat dropped because the FIFO was full
//   unf_err_o           pulse: FIFO empty in a clock that should have carried data
//
// Every output is a register loaded from the decoded next state, so the FSM
// state held in state_q always describes what the pins show right now.

module ddr5_phy_wrdata_burst_gen #(
    parameter int pDRAM_SIZE  = 4,
    parameter int pNUM_PHASES = 4,
    parameter int pFIFO_DEPTH = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    input  logic [1:0]                            cfg_bl_i,
    input  logic [1:0]                            cfg_pre_i,
    input  logic                                  cfg_post_i,
    input  logic                                  cfg_crc_i,
    input  logic [pNUM_PHASES-1:0]                dfi_wrdata_en_i,
    input  logic [pNUM_PHASES*2*pDRAM_SIZE-1:0]   dfi_wrdata_i,
    input  logic [pNUM_PHASES*pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_i,
    output logic [2*pDRAM_SIZE-1:0]               DQ_o,
    output logic                                  DQ_valid_o,
    output logic [pDRAM_SIZE/4-1:0]               DM_o,
    output logic [1:0]                            DQS_o,
    output logic [1:0]                            DQS_valid_o,
    output logic                                  busy_o,
    output logic                                  ovf_err_o,
    output logic                                  unf_err_o
);

    localparam int DW = 2 * pDRAM_SIZE;
    localparam int MW = pDRAM_SIZE / 4;
    localparam int EW = DW + MW;
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_POST = 3'd3
`ifdef DDR5_WR_CRC_EN
        , S_CRC = 3'd4
`endif
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [EW-1:0]          mem [pFIFO_DEPTH];
    logic [CW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          fifo_cnt, free_cnt, push_cnt, acc, fifo_cnt_nx;
    logic [AW-1:0]          wr_off [pNUM_PHASES];
    logic [pNUM_PHASES-1:0] wr_sel;
    logic                   fifo_has, pop, ovf_d;
    logic [EW-1:0]          rd_entry;

    assign fifo_cnt = wr_ptr_q - rd_ptr_q;
    assign fifo_has = (fifo_cnt != '0);
    assign rd_entry = mem[rd_ptr_q[AW-1:0]];

    // Enabled phases take consecutive slots in phase order. A pop in the same
    // clock frees one slot, so capacity is judged after the pop.
    always_comb begin
        free_cnt = CW'(pFIFO_DEPTH) - fifo_cnt + CW'(pop);
        acc      = '0;
        ovf_d    = 1'b0;
        wr_sel   = '0;
        for (int p = 0; p < pNUM_PHASES; p++) begin
            wr_off[p] = acc[AW-1:0];
            if (enable_i && dfi_wrdata_en_i[p]) begin
                if (acc < free_cnt) begin
                    wr_sel[p] = 1'b1;
                    acc       = acc + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        push_cnt    = acc;
        fifo_cnt_nx = fifo_cnt - CW'(pop) + push_cnt;
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < pNUM_PHASES; p++) begin
            if (wr_sel[p]) begin
                mem[wr_ptr_q[AW-1:0] + wr_off[p]] <=
                    {dfi_wrdata_mask_i[p*MW +: MW], dfi_wrdata_i[p*DW +: DW]};
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;        // preamble / postamble clock index
    logic [3:0]    beat_q, beat_d;      // data clock index within the burst
    logic [1:0]    bl_q, pre_q;
    logic          post_q;
    logic          latch, burst_end;
    logic [1:0]    bl_eff, pre_eff;
    logic          bc8_eff;
    logic [3:0]    last_beat;

    logic [DW-1:0] dq_d;
    logic [MW-1:0] dm_d;
    logic          dqv_d, unf_d, busy_d;
    logic [1:0]    dqs_d, dqsv_d;

`ifdef DDR5_WR_CRC_EN
    localparam int NG = pDRAM_SIZE / 4;
    logic          crc_q;
    logic [7:0]    crc_acc_q [NG];
    logic [7:0]    crc_acc_d [NG];
    logic [7:0]    crc_c;
    logic [DW-1:0] crc_in;
`else
    logic          unused_cfg_crc;
    assign unused_cfg_crc = cfg_crc_i;
`endif

    assign last_beat = (bl_q == 2'b10) ? 4'd15 : 4'd7;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        latch     = 1'b0;
        burst_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_has) begin
                    state_d = S_PRE;
                    cnt_d   = 2'd0;
                    latch   = 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == pre_q) begin
                    state_d = S_DATA;
                    beat_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DATA: begin
                if (beat_q == last_beat) burst_end = 1'b1;
                else                     beat_d    = beat_q + 4'd1;
`ifdef DDR5_WR_CRC_EN
                // The CRC slot after every 8th data clock takes over the
                // burst-end decision for that clock.
                if (crc_q && (beat_q[2:0] == 3'd7)) begin
                    state_d   = S_CRC;
                    beat_d    = beat_q;
                    burst_end = 1'b0;
                end
`endif
            end
`ifdef DDR5_WR_CRC_EN
            S_CRC: begin
                if (beat_q == last_beat) begin
                    burst_end = 1'b1;
                end else begin
                    state_d = S_DATA;
                    beat_d  = beat_q + 4'd1;
                end
            end
`endif
            S_POST: begin
                if (post_q && (cnt_q == 2'd0)) begin
                    cnt_d = 2'd1;
                end else if (fifo_has) begin
                    state_d = S_PRE;
                    cnt_d   = 2'd0;
                    latch   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Queued data at the end of a burst joins the next burst seamlessly.
        if (burst_end) begin
            if (fifo_has) begin
                state_d = S_DATA;
                beat_d  = 4'd0;
                latch   = 1'b1;
            end else begin
                state_d = S_POST;
                cnt_d   = 2'd0;
            end
        end

        // Configuration seen by the clock being loaded into the outputs.
        bl_eff  = latch ? cfg_bl_i  : bl_q;
        pre_eff = latch ? cfg_pre_i : pre_q;
        bc8_eff = (bl_eff == 2'b01);

        pop    = 1'b0;
        dq_d   = '0;
        dm_d   = '0;
        dqv_d  = 1'b0;
        dqs_d  = 2'b00;
        dqsv_d = 2'b00;
        unf_d  = 1'b0;

        case (state_d)
            S_PRE: begin
                dqsv_d = 2'b11;
                dqs_d  = (cnt_d == pre_eff) ? 2'b10 : 2'b00;
            end
            S_DATA: begin
                dqv_d  = 1'b1;
                dqs_d  = 2'b10;
                dqsv_d = 2'b11;
                if (bc8_eff && (beat_d >= 4'd4)) begin
                    dm_d = '1;              // BC8 chop fill
                end else if (fifo_has) begin
                    pop  = 1'b1;
                    dq_d = rd_entry[DW-1:0];
                    dm_d = rd_entry[EW-1:DW];
                end else begin
                    dm_d  = '1;
                    unf_d = 1'b1;
                end
            end
`ifdef DDR5_WR_CRC_EN
            S_CRC: begin
                dqv_d  = 1'b1;
                dqs_d  = 2'b10;
                dqsv_d = 2'b11;
                for (int g = 0; g < NG; g++) begin
                    dq_d[4*g +: 4]              = crc_acc_q[g][3:0];
                    dq_d[pDRAM_SIZE + 4*g +: 4] = crc_acc_q[g][7:4];
                end
            end
`endif
            S_POST: begin
                if (post_q && (cnt_d == 2'd0)) begin
                    dqs_d  = 2'b10;
                    dqsv_d = 2'b11;
                end else begin
                    dqsv_d = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign busy_d = (state_d != S_IDLE) || (fifo_cnt_nx != '0);

`ifdef DDR5_WR_CRC_EN
    // CRC8, poly x^8+x^2+x+1, one register per DQ nibble group. Bits enter in
    // beat order, lane 0 first. BC8 fill clocks contribute all ones.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    always_comb begin
        crc_c  = 8'h00;
        crc_in = (bc8_eff && (beat_d >= 4'd4)) ? {DW{1'b1}} : dq_d;
        for (int g = 0; g < NG; g++) begin
            crc_c = (beat_d[2:0] == 3'd0) ? 8'h00 : crc_acc_q[g];
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < 4; l++) begin
                    crc_c = crc8_step(crc_c, crc_in[b*pDRAM_SIZE + 4*g + l]);
                end
            end
            crc_acc_d[g] = crc_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 1'b0;
            for (int g = 0; g < NG; g++) crc_acc_q[g] <= 8'h00;
        end else begin
            if (latch) crc_q <= cfg_crc_i;
            if (state_d == S_DATA) begin
                for (int g = 0; g < NG; g++) crc_acc_q[g] <= crc_acc_d[g];
            end
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            beat_q      <= 4'd0;
            bl_q        <= 2'b00;
            pre_q       <= 2'b00;
            post_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            DQ_o        <= '0;
            DQ_valid_o  <= 1'b0;
            DM_o        <= '0;
            DQS_o       <= 2'b00;
            DQS_valid_o <= 2'b00;
            busy_o      <= 1'b0;
            ovf_err_o   <= 1'b0;
            unf_err_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            if (latch) begin
                bl_q   <= cfg_bl_i;
                pre_q  <= cfg_pre_i;
                post_q <= cfg_post_i;
            end
            wr_ptr_q    <= wr_ptr_q + push_cnt;
            rd_ptr_q    <= rd_ptr_q + CW'(pop);
            DQ_o        <= dq_d;
            DQ_valid_o  <= dqv_d;
            DM_o        <= dm_d;
            DQS_o       <= dqs_d;
            DQS_valid_o <= dqsv_d;
            busy_o      <= busy_d;
            ovf_err_o   <= ovf_d;
            unf_err_o   <= unf_d;
        end
    end

endmodule

// File: tb/tb_ddr5_phy_wrdata_burst_gen.sv
// Testbench for ddr5_phy_wrdata_burst_gen (default parameters: x4, 4 phases,
// 8-entry FIFO). A burst-level reference model expands every burst into a
// list of pin slots (preamble, data, fill, CRC, postamble) and plays them out
// one per clock against a queue of stored beats.

module tb_ddr5_phy_wrdata_burst_gen;

    localparam int DS    = 4;
    localparam int NP    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 2 * DS;
    localparam int MW    = DS / 4;
    localparam int NG    = DS / 4;
    localparam int EW    = DW + MW;
    localparam int OW    = DW + MW + 8;

    localparam int K_IDLE = 0, K_PRE = 1, K_PRE_LAST = 2, K_DATA = 3,
                   K_FILL = 4, K_CRC = 5, K_POST_HI = 6, K_POST_LO = 7;

    // ------------------------------------------------ clock / reset / DUT
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [1:0]      cfg_bl = 2'b00, cfg_pre = 2'b00;
    logic            cfg_post = 1'b0, cfg_crc = 1'b0;
    logic [NP-1:0]   wen = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP*MW-1:0] wmask = '0;

    logic [DW-1:0]   dq;
    logic            dq_valid;
    logic [MW-1:0]   dm;
    logic [1:0]      dqs, dqs_valid;
    logic            busy, ovf_err, unf_err;
    logic [OW-1:0]   out_v;

    always #5 clk = ~clk;

    ddr5_phy_wrdata_burst_gen #(
        .pDRAM_SIZE (DS),
        .pNUM_PHASES(NP),
        .pFIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .cfg_bl_i         (cfg_bl),
        .cfg_pre_i        (cfg_pre),
        .cfg_post_i       (cfg_post),
        .cfg_crc_i        (cfg_crc),
        .dfi_wrdata_en_i  (wen),
        .dfi_wrdata_i     (wdata),
        .dfi_wrdata_mask_i(wmask),
        .DQ_o             (dq),
        .DQ_valid_o       (dq_valid),
        .DM_o             (dm),
        .DQS_o            (dqs),
        .DQS_valid_o      (dqs_valid),
        .busy_o           (busy),
        .ovf_err_o        (ovf_err),
        .unf_err_o        (unf_err)
    );

    assign out_v = {dq, dm, dq_valid, dqs, dqs_valid, busy, ovf_err, unf_err};

    // ------------------------------------------------ reference model
    logic [EW-1:0] m_fifo [$];
    int            plan [$];
    bit            cur_last;
    bit            m_crc;
    logic [63:0]   cacc [NG];
    int            cn;
    logic [OW-1:0] exp_v;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    string tag = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] crc8(input logic [63:0] bits);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        plan.delete();
        cur_last = 1'b0;
        m_crc    = 1'b0;
        cn       = 0;
    endtask

    task automatic build_burst(input bit with_pre);
        int n;
        bit bc8;
        n   = (cfg_bl == 2'b10) ? 16 : 8;
        bc8 = (cfg_bl == 2'b01);
`ifdef DDR5_WR_CRC_EN
        m_crc = cfg_crc;
`else
        m_crc = 1'b0;
`endif
        cn = 0;
        if (with_pre) begin
            for (int i = 0; i <= int'(cfg_pre); i++)
                plan.push_back((i == int'(cfg_pre)) ? K_PRE_LAST : K_PRE);
        end
        for (int i = 0; i < n; i++) begin
            plan.push_back((bc8 && i >= 4) ? K_FILL : K_DATA);
            if (m_crc && (i % 8 == 7)) plan.push_back(K_CRC);
        end
        plan[plan.size()-1] = plan[plan.size()-1] + 16;   // burst-final slot
        if (cfg_post) plan.push_back(K_POST_HI);
        plan.push_back(K_POST_LO);
    endtask

    task automatic crc_collect(input logic [DW-1:0] v);
        if (m_crc) begin
            for (int g = 0; g < NG; g++)
                for (int b = 0; b < 2; b++)
                    for (int l = 0; l < 4; l++)
                        cacc[g][cn + b*4 + l] = v[b*DS + 4*g + l];
            cn = cn + 8;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        int            cnt0, slot, kind;
        logic [DW-1:0] e_dq;
        logic [MW-1:0] e_dm;
        logic          e_dqv, e_busy, e_ovf, e_unf;
        logic [1:0]    e_dqs, e_dqsv;
        logic [EW-1:0] ent;
        logic [7:0]    c;
        cnt0 = m_fifo.size();
        if (cur_last && cnt0 > 0) begin
            plan.delete();
            build_burst(1'b0);
        end else if (plan.size() == 0 && cnt0 > 0) begin
            build_burst(1'b1);
        end
        slot = K_IDLE;
        if (plan.size() > 0) slot = plan.pop_front();
        kind     = slot % 16;
        cur_last = (slot >= 16);

        e_dq = '0; e_dm = '0; e_dqv = 1'b0; e_dqs = 2'b00; e_dqsv = 2'b00;
        e_ovf = 1'b0; e_unf = 1'b0;
        case (kind)
            K_PRE:      e_dqsv = 2'b11;
            K_PRE_LAST: begin e_dqsv = 2'b11; e_dqs = 2'b10; end
            K_DATA: begin
                e_dqv = 1'b1; e_dqs = 2'b10; e_dqsv = 2'b11;
                if (m_fifo.size() > 0) begin
                    ent  = m_fifo.pop_front();
                    e_dq = ent[DW-1:0];
                    e_dm = ent[EW-1:DW];
                end else begin
                    e_dm  = '1;
                    e_unf = 1'b1;
                end
                crc_collect(e_dq);
            end
            K_FILL: begin
                e_dqv = 1'b1; e_dqs = 2'b10; e_dqsv = 2'b11; e_dm = '1;
                crc_collect({DW{1'b1}});
            end
            K_CRC: begin
                e_dqv = 1'b1; e_dqs = 2'b10; e_dqsv = 2'b11;
                for (int g = 0; g < NG; g++) begin
                    c = crc8(cacc[g]);
                    e_dq[4*g +: 4]      = c[3:0];
                    e_dq[DS + 4*g +: 4] = c[7:4];
                end
                cn = 0;
            end
            K_POST_HI: begin e_dqs = 2'b10; e_dqsv = 2'b11; end
            K_POST_LO: e_dqsv = 2'b10;
            default: ;
        endcase

        for (int p = 0; p < NP; p++) begin
            if (enable && wen[p]) begin
                if (m_fifo.size() < DEPTH)
                    m_fifo.push_back({wmask[p*MW +: MW], wdata[p*DW +: DW]});
                else
                    e_ovf = 1'b1;
            end
        end
        e_busy = (kind != K_IDLE) || (m_fifo.size() > 0);
        exp_v  = {e_dq, e_dm, e_dqv, e_dqs, e_dqsv, e_busy, e_ovf, e_unf};
    endtask

    // ------------------------------------------------ scoreboard
    task automatic check();
        tests++;
        assert (out_v === exp_v)
        else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, out_v, exp_v);
        end
    endtask

    // ------------------------------------------------ driver tasks
    task automatic drive(input logic [NP-1:0] e, input logic [NP*DW-1:0] d,
                         input logic [NP*MW-1:0] m);
        @(negedge clk);
        wen = e; wdata = d; wmask = m;
        @(posedge clk);
        model_step();
        #1 check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0);
    endtask

    task automatic set_cfg(input logic [1:0] bl, input logic [1:0] pre,
                           input logic post, input logic crc);
        cfg_bl = bl; cfg_pre = pre; cfg_post = post; cfg_crc = crc;
    endtask

    function automatic logic [NP*DW-1:0] p0(input logic [DW-1:0] b);
        logic [NP*DW-1:0] v;
        v = '0;
        v[DW-1:0] = b;
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] rnd_data();
        logic [NP*DW-1:0] v;
        for (int i = 0; i < NP*DW; i += 8) v[i +: 8] = 8'($urandom);
        return v;
    endfunction

    // ------------------------------------------------ directed + random steps
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 exp_v = '0;
        check();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        tag = "idle";
        idle(3);

        tag = "t2_bl16";
        set_cfg(2'b00, 2'd1, 1'b0, 1'b0);
        repeat (8) drive(4'b0001, p0(8'hAA), '0);
        idle(14);

        tag = "t4_bc8";
        set_cfg(2'b01, 2'd0, 1'b0, 1'b0);
        drive(4'b0001, p0(8'h5A), 4'b0000);
        drive(4'b0001, p0(8'h5A), 4'b0001);
        drive(4'b0001, p0(8'h5A), 4'b0000);
        drive(4'b0001, p0(8'h5A), 4'b0000);
        idle(14);

        tag = "t5_seamless";
        set_cfg(2'b00, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(4'b0001, p0(8'(i * 17 + 3)), '0);
        idle(12);

        tag = "t3_bl32_crc";
        set_cfg(2'b10, 2'd3, 1'b1, 1'b1);
        repeat (16) drive(4'b0001, p0(8'hAA), '0);
        idle(30);

        tag = "t6_ovf";
        set_cfg(2'b00, 2'd0, 1'b0, 1'b0);
        repeat (3) drive(4'b1111, rnd_data(), '0);
        idle(20);
        tag = "t6_unf";
        drive(4'b0001, p0(8'h11), '0);
        drive(4'b0010, rnd_data(), '0);
        idle(16);

        tag = "phase_gaps";
        set_cfg(2'b11, 2'd2, 1'b1, 1'b0);
        drive(4'b1010, rnd_data(), 4'b1000);
        drive(4'b0101, rnd_data(), 4'b0001);
        drive(4'b1001, rnd_data(), '0);
        idle(16);

        tag = "enable_low";
        set_cfg(2'b00, 2'd0, 1'b0, 1'b0);
        drive(4'b0011, rnd_data(), '0);
        enable = 1'b0;
        repeat (4) drive(4'b1111, rnd_data(), '0);
        enable = 1'b1;
        idle(16);

        tag = "random";
        for (int i = 0; i < 700; i++) begin
            if (i % 37 == 0)
                set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            enable = ($urandom_range(0, 15) != 0);
            if ((i / 60) % 3 == 2)
                drive('0, '0, '0);
            else if ($urandom_range(0, 2) == 0)
                drive(NP'($urandom), rnd_data(), NP'($urandom));
            else
                drive('0, rnd_data(), '0);
        end
        enable = 1'b1;
        idle(40);

        tag = "t1_reset";
        set_cfg(2'b00, 2'd1, 1'b0, 1'b0);
        repeat (8) drive(4'b0001, p0(8'h3C), '0);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1 exp_v = '0;
        check();
        model_reset();
        @(posedge clk);
        #1 check();
        @(negedge clk);
        rst = 1'b0;
        tag = "after_reset";
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
